// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Contents: opcode constants, the controller state type, datapath mux-select
// encodings and trap-cause encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_WB_MEM,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory wait states.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   waiting     - controller sits in a memory wait state with mem_ready low
//   clear       - controller changes state this cycle; restart the count
//   expired     - this cycle is the last allowed wait cycle and memory is still busy
// TIMEOUT_CYCLES = 0 disables the watchdog.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // Count holds the number of wait cycles already spent, so the current
  // cycle is wait number count+1.
  assign expired = (TIMEOUT_CYCLES != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath (shared memory, one ALU).
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   Opcode, Zero       - IR[6:0] and ALU zero flag
//   mem_ready          - memory completes the current access this cycle
//   PCWrite..RegWrite  - datapath enables and mux selects
//   instr_done         - pulse on the final cycle of a retired instruction
//   trap, trap_cause   - sticky fault indication, cleared only by reset
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory responds
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | compute load/store address
// MEMRD    | load access, wait for memory
// MEMWR    | store access, wait for memory, retire
// WB_MEM   | write load data to register file, retire
// EXEC_R   | ALU on regA, regB
// EXEC_I   | ALU on regA, imm
// WB_ALU   | write ALUOut to register file, retire
// BRANCH   | compare, take branch when Zero, retire
// TRAP     | halted after illegal opcode or bus timeout
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_t     state, next_state;
  logic [1:0] cause_q, next_cause;
  logic       waiting, expired;

  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .clear   (next_state != state),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    next_cause = CAUSE_ILLEGAL;
    if (expired) begin
      next_state = S_TRAP;
      next_cause = CAUSE_TIMEOUT;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) next_state = S_DECODE;
        S_DECODE: begin
          case (Opcode)
            LW, SW: next_state = S_MEMADR;
            R_TYPE: next_state = S_EXEC_R;
            I_TYPE: next_state = S_EXEC_I;
            BR:     next_state = S_BRANCH;
            default: next_state = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          if (Opcode == LW)      next_state = S_MEMRD;
          else if (Opcode == SW) next_state = S_MEMWR;
          else                   next_state = S_TRAP;
        end
        S_MEMRD:  if (mem_ready) next_state = S_WB_MEM;
        S_MEMWR:  if (mem_ready) next_state = S_FETCH;
        S_WB_MEM, S_WB_ALU, S_BRANCH: next_state = S_FETCH;
        S_EXEC_R, S_EXEC_I:           next_state = S_WB_ALU;
        default:  next_state = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state <= next_state;
      if ((next_state == S_TRAP) && (state != S_TRAP)) cause_q <= next_cause;
    end
  end

  // Reset overrides the decode so no request or enable leaks out while the
  // state register already reads FETCH.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    PCSrc      = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;
    if (!reset) begin
      trap_cause = cause_q;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWR: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_MEM: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = SRCA_REGA;
          ALUOp   = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        S_WB_ALU: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_REGA;
          ALUOp      = ALUOP_BRANCH;
          PCSrc      = 1'b1;
          PCWrite    = Zero;
          instr_done = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller, built with a 4-cycle watchdog.
// Each step drives Opcode/Zero/mem_ready, checks every output packed into
// one vector against a hand-written expectation, then advances one clock.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       PCSrc, MemtoReg, RegWrite, instr_done, trap;
  logic [1:0] trap_cause;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  logic [17:0] obs;
  assign obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSrc, MemtoReg, RegWrite, instr_done, trap, trap_cause};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Argument order matches obs packing.
  function automatic logic [17:0] v(input logic pcw, input logic adr, input logic mr,
                                    input logic mw, input logic irw, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] op,
                                    input logic pcs, input logic m2r, input logic rw,
                                    input logic done, input logic tr, input logic [1:0] cause);
    return {pcw, adr, mr, mw, irw, sa, sb, op, pcs, m2r, rw, done, tr, cause};
  endfunction

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic z,
                      input logic rdy, input logic [17:0] e);
    Opcode = op;
    Zero = z;
    mem_ready = rdy;
    #1;
    chk(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outputs", obs, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [17:0] e_fetch_rdy, e_fetch_wait, e_decode, e_memadr, e_memrd, e_memwr_wait,
               e_memwr_rdy, e_wb_mem, e_exec_r, e_exec_i, e_wb_alu, e_br_taken,
               e_br_not, e_trap_ill, e_trap_to;

  initial begin
    e_fetch_rdy  = v(1,0,1,0,1, 2'b00,2'b10,2'b00, 0,0,0,0,0, 2'b00);
    e_fetch_wait = v(0,0,1,0,0, 2'b00,2'b10,2'b00, 0,0,0,0,0, 2'b00);
    e_decode     = v(0,0,0,0,0, 2'b01,2'b01,2'b00, 0,0,0,0,0, 2'b00);
    e_memadr     = v(0,0,0,0,0, 2'b10,2'b01,2'b00, 0,0,0,0,0, 2'b00);
    e_memrd      = v(0,1,1,0,0, 2'b00,2'b00,2'b00, 0,0,0,0,0, 2'b00);
    e_memwr_wait = v(0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,0,0, 2'b00);
    e_memwr_rdy  = v(0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,1,0, 2'b00);
    e_wb_mem     = v(0,0,0,0,0, 2'b00,2'b00,2'b00, 0,1,1,1,0, 2'b00);
    e_exec_r     = v(0,0,0,0,0, 2'b10,2'b00,2'b10, 0,0,0,0,0, 2'b00);
    e_exec_i     = v(0,0,0,0,0, 2'b10,2'b01,2'b10, 0,0,0,0,0, 2'b00);
    e_wb_alu     = v(0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,1,0, 2'b00);
    e_br_taken   = v(1,0,0,0,0, 2'b10,2'b00,2'b01, 1,0,0,1,0, 2'b00);
    e_br_not     = v(0,0,0,0,0, 2'b10,2'b00,2'b01, 1,0,0,1,0, 2'b00);
    e_trap_ill   = v(0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0,1, 2'b01);
    e_trap_to    = v(0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0,1, 2'b10);

    #2;
    do_reset();

    // addi, memory always ready: 4 cycles, single retire pulse
    step("addi_fetch",  OP_I, 0, 1, e_fetch_rdy);
    step("addi_decode", OP_I, 0, 1, e_decode);
    step("addi_exec",   OP_I, 0, 1, e_exec_i);
    step("addi_wb",     OP_I, 0, 1, e_wb_alu);

    // R-type
    step("r_fetch",  OP_R, 0, 1, e_fetch_rdy);
    step("r_decode", OP_R, 0, 1, e_decode);
    step("r_exec",   OP_R, 0, 1, e_exec_r);
    step("r_wb",     OP_R, 0, 1, e_wb_alu);

    // LW with 3-cycle read latency, plus one fetch wait cycle
    step("lw_fetch_wait", OP_LW, 0, 0, e_fetch_wait);
    step("lw_fetch",      OP_LW, 0, 1, e_fetch_rdy);
    step("lw_decode",     OP_LW, 0, 1, e_decode);
    step("lw_memadr",     OP_LW, 0, 1, e_memadr);
    step("lw_memrd1",     OP_LW, 0, 0, e_memrd);
    step("lw_memrd2",     OP_LW, 0, 0, e_memrd);
    step("lw_memrd3",     OP_LW, 0, 1, e_memrd);
    step("lw_wb",         OP_LW, 0, 1, e_wb_mem);

    // BEQ taken / not taken; mem_ready ignored in BRANCH
    step("beq1_fetch",  OP_BR, 1, 1, e_fetch_rdy);
    step("beq1_decode", OP_BR, 1, 0, e_decode);
    step("beq1_branch", OP_BR, 1, 0, e_br_taken);
    step("beq0_fetch",  OP_BR, 0, 1, e_fetch_rdy);
    step("beq0_decode", OP_BR, 0, 1, e_decode);
    step("beq0_branch", OP_BR, 0, 1, e_br_not);

    // SW, ready on the 4th wait cycle: ready wins over the watchdog
    step("sw_fetch",  OP_SW, 0, 1, e_fetch_rdy);
    step("sw_decode", OP_SW, 0, 1, e_decode);
    step("sw_memadr", OP_SW, 0, 1, e_memadr);
    step("sw_wait1",  OP_SW, 0, 0, e_memwr_wait);
    step("sw_wait2",  OP_SW, 0, 0, e_memwr_wait);
    step("sw_wait3",  OP_SW, 0, 0, e_memwr_wait);
    step("sw_done4",  OP_SW, 0, 1, e_memwr_rdy);
    step("sw_back_fetch", OP_SW, 0, 1, e_fetch_rdy);

    // SW never acknowledged: timeout trap after 4 wait cycles
    step("swto_decode", OP_SW, 0, 1, e_decode);
    step("swto_memadr", OP_SW, 0, 1, e_memadr);
    step("swto_wait1",  OP_SW, 0, 0, e_memwr_wait);
    step("swto_wait2",  OP_SW, 0, 0, e_memwr_wait);
    step("swto_wait3",  OP_SW, 0, 0, e_memwr_wait);
    step("swto_wait4",  OP_SW, 0, 0, e_memwr_wait);
    step("swto_trap",   OP_SW, 0, 1, e_trap_to);
    step("swto_hold",   OP_I,  0, 1, e_trap_to);

    // Illegal opcode: trap held for 100 cycles regardless of inputs
    do_reset();
    step("ill_fetch",  OP_BAD, 0, 1, e_fetch_rdy);
    step("ill_decode", OP_BAD, 0, 1, e_decode);
    for (int i = 0; i < 100; i++) begin
      step("ill_trap_hold", (i % 3 == 0) ? OP_I : OP_BAD, i[0], i[1], e_trap_ill);
    end

    // Reset mid-MEMRD with mem_ready high
    do_reset();
    step("rst_fetch",  OP_LW, 0, 1, e_fetch_rdy);
    step("rst_decode", OP_LW, 0, 1, e_decode);
    step("rst_memadr", OP_LW, 0, 1, e_memadr);
    Opcode = OP_LW;
    mem_ready = 1'b1;
    #1;
    chk("rst_memrd", obs, e_memrd);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_zero", obs, '0);
    @(posedge clk);
    #1;
    chk("rst_held_zero", obs, '0);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_release_fetch", obs, e_fetch_wait);
    @(posedge clk);
    #1;
    step("rst_fetch_again", OP_LW, 0, 1, e_fetch_rdy);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
